// File: rtl/tx_stream_scheduler.sv
// Transmit arbiter between the ordered-set stream and the framed DLLP/TLP stream.
// Forwards whole packets and holds off link traffic while a SKP ordered set is owed.
module tx_stream_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 5,
  parameter int SKP_INTERVAL = 1538,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  link_up_i,

  input  logic [DATA_WIDTH-1:0] s_os_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_os_axis_tkeep,
  input  logic                  s_os_axis_tvalid,
  input  logic                  s_os_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_os_axis_tuser,
  output logic                  s_os_axis_tready,

  input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
  input  logic                  s_dllp_axis_tvalid,
  input  logic                  s_dllp_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
  output logic                  s_dllp_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,

  output logic                  skp_req_o,
  input  logic                  skp_ack_i,
  output logic                  skp_overrun_o
);

  typedef enum logic [1:0] {IDLE, OS_PKT, DLLP_PKT, SKP_WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SKP_INTERVAL - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] skp_cnt;
  logic                 skp_pending;
  logic                 skp_overrun;
  logic                 os_eop, dllp_eop;

  assign os_eop   = s_os_axis_tvalid   & s_os_axis_tready   & s_os_axis_tlast;
  assign dllp_eop = s_dllp_axis_tvalid & s_dllp_axis_tready & s_dllp_axis_tlast;

  // SKP interval timer; expiry takes precedence over a same-cycle ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
      skp_overrun <= 1'b0;
    end else if (!link_up_i) begin
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
    end else if (skp_cnt == CNT_LAST) begin
      skp_cnt     <= '0;
      skp_pending <= 1'b1;
      if (skp_pending && !skp_ack_i) skp_overrun <= 1'b1;
    end else begin
      skp_cnt <= skp_cnt + 1'b1;
      if (skp_ack_i) skp_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_os_axis_tvalid)                     state_nxt = OS_PKT;
        else if (skp_pending)                     state_nxt = SKP_WAIT;
        else if (s_dllp_axis_tvalid && link_up_i) state_nxt = DLLP_PKT;
      end
      OS_PKT:   if (os_eop)   state_nxt = IDLE;
      DLLP_PKT: if (dllp_eop) state_nxt = IDLE;
      SKP_WAIT: begin
        if (s_os_axis_tvalid) state_nxt = OS_PKT;
        else if (!skp_pending) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is the registered state, so the mux never switches mid-packet.
  always_comb begin
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;
    m_axis_tuser       = '0;
    s_os_axis_tready   = 1'b0;
    s_dllp_axis_tready = 1'b0;
    case (state)
      OS_PKT: begin
        m_axis_tdata     = s_os_axis_tdata;
        m_axis_tkeep     = s_os_axis_tkeep;
        m_axis_tvalid    = s_os_axis_tvalid;
        m_axis_tlast     = s_os_axis_tlast;
        m_axis_tuser     = s_os_axis_tuser;
        s_os_axis_tready = m_axis_tready;
      end
      DLLP_PKT: begin
        m_axis_tdata       = s_dllp_axis_tdata;
        m_axis_tkeep       = s_dllp_axis_tkeep;
        m_axis_tvalid      = s_dllp_axis_tvalid;
        m_axis_tlast       = s_dllp_axis_tlast;
        m_axis_tuser       = s_dllp_axis_tuser;
        s_dllp_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign skp_req_o     = skp_pending;
  assign skp_overrun_o = skp_overrun;

endmodule

// File: tb/tb_tx_stream_scheduler.sv
// Bench for tx_stream_scheduler: IDLE arbitration table, directed corner sequences,
// and randomized traffic checked against a packet scoreboard and SKP timing model.
module tb_tx_stream_scheduler;
  localparam int DW = 32;
  localparam int KW = DW/8;
  localparam int UW = 5;
  localparam int SI = 16;
  localparam int CW = 16;
  localparam logic [DW-1:0] OSD = 32'h0A5A_0001;
  localparam logic [DW-1:0] DLD = 32'h8000_BEEF;

  logic clk = 1'b0, rst_n = 1'b0, link_up = 1'b0;
  logic [DW-1:0] os_d = '0, dl_d = '0, m_d;
  logic [KW-1:0] os_k = '0, dl_k = '0, m_k;
  logic [UW-1:0] os_u = '0, dl_u = '0, m_u;
  logic os_v = 1'b0, os_l = 1'b0, os_r, dl_v = 1'b0, dl_l = 1'b0, dl_r;
  logic m_v, m_l, m_rdy = 1'b0;
  logic skp_req, skp_ack = 1'b0, skp_ovr;

  always #5 clk = ~clk;

  tx_stream_scheduler #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                        .SKP_INTERVAL(SI), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .link_up_i(link_up),
    .s_os_axis_tdata(os_d), .s_os_axis_tkeep(os_k), .s_os_axis_tvalid(os_v),
    .s_os_axis_tlast(os_l), .s_os_axis_tuser(os_u), .s_os_axis_tready(os_r),
    .s_dllp_axis_tdata(dl_d), .s_dllp_axis_tkeep(dl_k), .s_dllp_axis_tvalid(dl_v),
    .s_dllp_axis_tlast(dl_l), .s_dllp_axis_tuser(dl_u), .s_dllp_axis_tready(dl_r),
    .m_axis_tdata(m_d), .m_axis_tkeep(m_k), .m_axis_tvalid(m_v),
    .m_axis_tlast(m_l), .m_axis_tuser(m_u), .m_axis_tready(m_rdy),
    .skp_req_o(skp_req), .skp_ack_i(skp_ack), .skp_overrun_o(skp_ovr));

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;
  typedef struct {
    int    cyc;
    logic  src;
    beat_t b;
  } rec_t;
  typedef struct {
    bit osv, dlv, link, mrdy;
    logic [DW-1:0] osd, dld;
    bit e_mv, e_otr, e_dtr;
    logic [DW-1:0] e_d;
  } vec_t;

  beat_t os_q[$], dl_q[$], os_exp[$], dl_exp[$];
  rec_t  log_q[$];
  int n_chk = 0, n_fail = 0;

  // engine controls
  int rdy_mode = 0, gap_rate = 0, ack_rate = 0, pkt_id = 0, cyc = 0, n_os_out = 0;
  bit link_cfg = 0, ack_req = 0, rel = 0;
  bit os_pop = 0, dl_pop = 0, in_pkt = 0, cur_src = 0;
  bit prev_tlast_hs = 0, prev_stall = 0, prev_osv = 0, prev_link = 0, prev_pend = 0;
  beat_t prev_out;
  // SKP reference: elapsed link-up cycles, pending flag, sticky overrun
  int up_cyc = 0;
  bit m_pend = 0, m_ovr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset();
    chk("rst_os_tready",   64'(os_r),    64'd0);
    chk("rst_dllp_tready", 64'(dl_r),    64'd0);
    chk("rst_m_tvalid",    64'(m_v),     64'd0);
    chk("rst_m_tdata",     64'(m_d),     64'd0);
    chk("rst_skp_req",     64'(skp_req), 64'd0);
    chk("rst_overrun",     64'(skp_ovr), 64'd0);
  endtask

  task automatic push_pkt(input bit src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {src, pkt_id[14:0], 16'(i)};
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = (i == len - 1);
      if (src) begin dl_q.push_back(b); dl_exp.push_back(b); end
      else     begin os_q.push_back(b); os_exp.push_back(b); end
    end
    pkt_id++;
  endtask

  task automatic eng_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset();
    os_v = 0; dl_v = 0; os_d = '0; dl_d = '0; os_l = 0; dl_l = 0;
    m_rdy = 0; skp_ack = 0; link_up = 0; link_cfg = 0; ack_req = 0; ack_rate = 0;
    gap_rate = 0; rdy_mode = 0;
    os_q.delete(); dl_q.delete(); os_exp.delete(); dl_exp.delete(); log_q.delete();
    os_pop = 0; dl_pop = 0; in_pkt = 0; prev_tlast_hs = 0; prev_stall = 0;
    prev_osv = 0; prev_link = 0; prev_pend = 0; n_os_out = 0;
    up_cyc = 0; m_pend = 0; m_ovr = 0; cyc = 0;
    repeat (2) @(negedge clk);
    rel = 1;
  endtask

  // One clock: drive at negedge, sample #1 later (values seen by the next posedge).
  task automatic cycle();
    beat_t ob, e;
    bit hs, osh, dlh, src;
    @(negedge clk);
    if (rel) begin rst_n = 1'b1; rel = 0; end
    if (os_pop) begin os_v = 0; os_q.pop_front(); os_pop = 0; end
    if (dl_pop) begin dl_v = 0; dl_q.pop_front(); dl_pop = 0; end
    if (!os_v && os_q.size() > 0 && $urandom_range(99) >= gap_rate) begin
      {os_d, os_k, os_u, os_l} = os_q[0]; os_v = 1;
    end
    if (!dl_v && dl_q.size() > 0 && $urandom_range(99) >= gap_rate) begin
      {dl_d, dl_k, dl_u, dl_l} = dl_q[0]; dl_v = 1;
    end
    link_up = link_cfg;
    case (rdy_mode)
      0: m_rdy = 1'b1;
      1: m_rdy = ~m_rdy;
      2: m_rdy = ($urandom_range(3) != 0);
      default: m_rdy = 1'b0;
    endcase
    skp_ack = ack_req || (ack_rate > 0 && m_pend && $urandom_range(99) < ack_rate)
              || (ack_rate > 0 && $urandom_range(199) == 0);
    ack_req = 0;
    #1;
    ob = {m_d, m_k, m_u, m_l};
    src = m_d[DW-1];
    if (prev_stall) begin
      chk("stall_valid", 64'(m_v), 64'd1);
      chk("stall_beat", 64'(ob), 64'(prev_out));
    end
    if (prev_tlast_hs) chk("gap_after_tlast", 64'(m_v), 64'd0);
    chk("skp_req", 64'(skp_req), 64'(m_pend));
    chk("skp_overrun", 64'(skp_ovr), 64'(m_ovr));
    if (m_v && in_pkt) chk("no_interleave", 64'(src), 64'(cur_src));
    if (m_v && !in_pkt) begin
      if (prev_osv || !prev_link || prev_pend) chk("grant_src", 64'(src), 64'd0);
      in_pkt = 1; cur_src = src;
    end
    hs  = m_v && m_rdy;
    osh = os_v && os_r;
    dlh = dl_v && dl_r;
    if (hs) begin
      chk("src_hs", 64'({osh, dlh}), src ? 64'd1 : 64'd2);
      if (src ? dl_exp.size() == 0 : os_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat: got %0h, expected none (cyc %0d)", ob.data, cyc);
      end else begin
        e = src ? dl_exp.pop_front() : os_exp.pop_front();
        chk(src ? "dllp_beat" : "os_beat", 64'(ob), 64'(e));
      end
      if (!src) n_os_out++;
      log_q.push_back('{cyc, src, ob});
      if (ob.last) in_pkt = 0;
    end else begin
      chk("no_src_hs", 64'({osh, dlh}), 64'd0);
    end
    prev_tlast_hs = hs && ob.last;
    prev_stall = m_v && !m_rdy;
    prev_out = ob;
    prev_osv = os_v; prev_link = link_up; prev_pend = m_pend;
    os_pop = osh; dl_pop = dlh;
    if (!link_up) begin
      up_cyc = 0; m_pend = 0;
    end else begin
      if (up_cyc % SI == SI - 1) begin
        if (m_pend && !skp_ack) m_ovr = 1;
        m_pend = 1;
      end else if (skp_ack) begin
        m_pend = 0;
      end
      up_cyc++;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int t0, rise, ack_cyc, bad, resume, drop;
    int ea[6] = '{1, 2, 4, 5, 6, 7};
    bit es[6] = '{0, 0, 1, 1, 1, 1};
    logic ovr_hist[70];

    // IDLE decision table: registered grant one cycle after reset release
    vt[0] = '{0, 0, 1, 1, OSD, DLD, 0, 0, 0, 32'h0};
    vt[1] = '{1, 0, 1, 1, OSD, DLD, 1, 1, 0, OSD};
    vt[2] = '{0, 1, 1, 1, OSD, DLD, 1, 0, 1, DLD};
    vt[3] = '{1, 1, 1, 1, OSD, DLD, 1, 1, 0, OSD};
    vt[4] = '{0, 1, 0, 1, OSD, DLD, 0, 0, 0, 32'h0};
    vt[5] = '{1, 1, 0, 0, OSD, DLD, 1, 0, 0, OSD};
    vt[6] = '{0, 1, 1, 0, OSD, DLD, 1, 0, 0, DLD};
    foreach (vt[i]) begin
      @(negedge clk);
      rst_n = 0;
      os_v = vt[i].osv; os_d = vt[i].osd; os_k = '1; os_u = '0; os_l = 0;
      dl_v = vt[i].dlv; dl_d = vt[i].dld; dl_k = '1; dl_u = '0; dl_l = 0;
      link_up = vt[i].link; m_rdy = vt[i].mrdy; skp_ack = 0;
      #1 chk_reset();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #1;
      chk("tbl_m_tvalid", 64'(m_v), 64'(vt[i].e_mv));
      chk("tbl_os_tready", 64'(os_r), 64'(vt[i].e_otr));
      chk("tbl_dllp_tready", 64'(dl_r), 64'(vt[i].e_dtr));
      chk("tbl_m_tdata", 64'(m_d), 64'(vt[i].e_d));
    end

    // Contention: OS 2-beat wins, one idle cycle, then DLLP 4-beat
    eng_reset();
    link_cfg = 1;
    push_pkt(0, 2); push_pkt(1, 4);
    repeat (12) cycle();
    chk("cont_beats", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("cont_cyc", 64'(log_q[i].cyc), 64'(ea[i]));
      chk("cont_src", 64'(log_q[i].src), 64'(es[i]));
    end

    // Backpressure: ready toggles every cycle
    eng_reset();
    link_cfg = 1; rdy_mode = 1;
    push_pkt(1, 4);
    repeat (14) cycle();
    chk("bp_beats", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("bp_order", 64'(log_q[i].b.data[15:0]), 64'(i));
      chk("bp_tlast", 64'(log_q[i].b.last), 64'(i == 3));
    end

    // Reset asserted with a stalled packet in flight
    eng_reset();
    link_cfg = 1; rdy_mode = 3;
    push_pkt(1, 4);
    repeat (3) cycle();
    chk("midpkt_valid", 64'(m_v), 64'd1);
    eng_reset();

    // Link down: DLLP blocked, OS still passes, SKP timer held at zero
    push_pkt(1, 2);
    for (int i = 0; i < 100; i++) begin
      if (i == 50) push_pkt(0, 1);
      cycle();
      chk("linkdown_dllp_tready", 64'(dl_r), 64'd0);
    end
    chk("linkdown_os_pass", 64'(n_os_out), 64'd1);
    link_cfg = 1; ack_rate = 0;
    t0 = cyc; rise = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (skp_req) begin rise = cyc - 1; break; end
    end
    chk("linkup_skp_rise", 64'(rise - t0), 64'd16);

    // SKP timing under continuous DLLP traffic
    eng_reset();
    link_cfg = 1;
    for (int i = 0; i < 8; i++) push_pkt(1, 4);
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (skp_req) begin rise = cyc - 1; break; end
    end
    chk("skp_rise", 64'(rise), 64'd16);
    repeat (8) cycle();
    push_pkt(0, 1);
    for (int i = 0; i < 20 && n_os_out == 0; i++) cycle();
    chk("skp_os_fwd", 64'(n_os_out), 64'd1);
    repeat (2) cycle();
    ack_req = 1; ack_cyc = cyc;
    repeat (30) cycle();
    bad = 0; resume = 0;
    foreach (log_q[i]) begin
      if (log_q[i].src && log_q[i].b.data[15:0] == 0 &&
          log_q[i].cyc >= 17 && log_q[i].cyc <= ack_cyc + 1) bad++;
      if (log_q[i].src && log_q[i].cyc > ack_cyc) resume++;
    end
    chk("skp_holds_dllp", 64'(bad), 64'd0);
    chk("dllp_resume", 64'(resume > 0), 64'd1);

    // Overrun: second expiry without ack, sticky afterwards
    eng_reset();
    link_cfg = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 40) ack_req = 1;
      cycle();
      ovr_hist[i] = skp_ovr;
    end
    chk("ovr_before", 64'(ovr_hist[31]), 64'd0);
    chk("ovr_set", 64'(ovr_hist[32]), 64'd1);
    drop = 0;
    for (int i = 32; i < 70; i++) if (!ovr_hist[i]) drop++;
    chk("ovr_sticky", 64'(drop), 64'd0);
    eng_reset();

    // Randomized traffic, backpressure, gaps, link flaps and acks
    link_cfg = 1; rdy_mode = 2; gap_rate = 20; ack_rate = 10;
    for (int i = 0; i < 3000; i++) begin
      if (os_q.size() < 6 && $urandom_range(99) < 8) push_pkt(0, $urandom_range(1, 3));
      if (dl_q.size() < 8 && $urandom_range(99) < 20) push_pkt(1, $urandom_range(1, 4));
      if ($urandom_range(999) < 5) link_cfg = ~link_cfg;
      cycle();
    end
    link_cfg = 1; rdy_mode = 0; ack_rate = 30;
    for (int i = 0; i < 3000; i++) begin
      if (os_exp.size() == 0 && dl_exp.size() == 0 && !in_pkt) break;
      cycle();
    end
    chk("drain_os", 64'(os_exp.size()), 64'd0);
    chk("drain_dllp", 64'(dl_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_stream_scheduler.md
# tx_stream_scheduler

Arbitrates the PHY transmit datapath between the ordered-set stream (from the OS generator) and the framed DLLP/TLP stream, forwarding one whole packet at a time to lane management on the PIPE TX user clock. It also times SKP ordered-set insertion: a free-running interval counter raises a SKP request to the OS generator and holds off link traffic at the next packet boundary until the SKP is sent.

## Interface
- DATA_WIDTH, 32, AXIS data width of both inputs and the output
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 5, tuser width
- SKP_INTERVAL, 1538, cycles between SKP requests; legal range 2..2^CNT_WIDTH-1
- CNT_WIDTH, 16, SKP counter width
- clk_i  in  1  PIPE TX user clock; sole clock
- rst_n_i  in  1  reset, asynchronous, active-low
- link_up_i  in  1  link up from LTSSM; gates DLLP traffic and SKP timing
- s_os_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  ordered-set stream
- s_os_axis_tready  out  1
- s_dllp_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  framed link stream
- s_dllp_axis_tready  out  1
- m_axis_tdata/tkeep/tvalid/tlast/tuser  out  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  to lane management
- m_axis_tready  in  1
- skp_req_o  out  1  request OS generator to emit one SKP OS
- skp_ack_i  in  1  one-cycle pulse: SKP OS fully queued
- skp_overrun_o  out  1  sticky: interval expired while a SKP was still pending

## Operation
- FSM states: IDLE, OS_PKT, DLLP_PKT, SKP_WAIT. Reset state IDLE.
- IDLE (no stream forwarded, both treadys 0, m_axis_tvalid 0), priority order evaluated each cycle:
  - s_os_axis_tvalid -> OS_PKT.
  - else skp_pending -> SKP_WAIT.
  - else s_dllp_axis_tvalid && link_up_i -> DLLP_PKT.
  - else stay.
- OS_PKT / DLLP_PKT: selected slave wired to master (tdata/tkeep/tlast/tuser/tvalid pass through, slave tready = m_axis_tready); unselected tready 0. Return to IDLE on handshake of the tlast beat. Grant is never changed mid-packet, including when link_up_i falls during DLLP_PKT (packet completes).
- SKP_WAIT: skp_req_o=1; DLLP blocked; on s_os_axis_tvalid -> OS_PKT; if skp_pending clears (ack) -> IDLE.
- SKP counter: while link_up_i=1 increments each cycle; at SKP_INTERVAL-1 wraps to 0 and sets skp_pending (if already set, set skp_overrun_o instead). link_up_i=0 holds counter at 0 and clears skp_pending.
- skp_ack_i clears skp_pending in any state; ack and expiry in the same cycle: pending stays set (expiry wins), no overrun.
- skp_overrun_o cleared only by reset.
- skp_req_o = skp_pending, registered-state based, asserted from SKP_WAIT entry and also while pending in OS_PKT/IDLE.

## Timing
- Reset values: all treadys 0, m_axis_tvalid 0, m_axis_tdata/tkeep/tuser/tlast 0 (muxed from IDLE), skp_req_o 0, skp_overrun_o 0, counter 0, state IDLE.
- Arbitration latency: 1 cycle (IDLE decision registered); zero-latency passthrough inside a packet. Back-to-back packets incur exactly one idle cycle between tlast handshake and next first beat.
- Output is AXIS-compliant: grant registered, so m_axis_tvalid/tdata never change while m_axis_tvalid=1 and m_axis_tready=0 unless the source violates AXIS.
- Counter expiry: skp_pending visible the cycle after counter value SKP_INTERVAL-1.
- Reset assertion mid-packet: immediate return to reset values; no completion of the packet.

## Test plan
- Reset: rst_n_i low with both sources valid -> all treadys 0, m_axis_tvalid 0, skp_req_o 0.
- Contention: OS 2-beat and DLLP 4-beat packets valid same cycle in IDLE, link up -> OS beats out first, one idle cycle, then 4 DLLP beats; no interleave.
- Backpressure: DLLP packet, m_axis_tready toggled 1/0 every cycle -> output beats stable while stalled, 4 beats delivered in order, tlast on beat 4.
- Link down: link_up_i=0, DLLP valid -> s_dllp_axis_tready stays 0 for 100 cycles; OS packet still passes; counter stays 0.
- SKP timing: SKP_INTERVAL=16, continuous DLLP traffic -> skp_req_o rises cycle 16, DLLP held after current tlast, OS SKP forwarded, skp_ack_i clears request, DLLP resumes.
- Overrun: SKP_INTERVAL=16, never ack -> skp_overrun_o sets at second expiry (cycle 32) and stays 1 until reset.
